// File: rtl/commit_queue_pkg.sv
// Shared core definitions for the commit queue: config defaults, the scoreboard
// entry layout and the transaction-ID width helper.
package commit_queue_pkg;

  localparam int unsigned NrScoreboardEntries = 8;
  localparam int unsigned NrCommitPorts       = 2;
  localparam int unsigned NrWbPorts           = 2;
  localparam int unsigned XLEN                = 32;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic [XLEN-1:0] data;
  } sb_entry_t;

  function automatic int unsigned id_w(input int unsigned nr_entries);
    return (nr_entries > 1) ? $clog2(nr_entries) : 1;
  endfunction

endpackage

// File: rtl/commit_queue.sv
// In-order commit queue: issue allocates at the next edge, commit outputs are combinational from state.
// Backpressure: issue_ready_o drops while full (registered count only); entries retire only on commit_ack_i.
module commit_queue
  import commit_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = NrScoreboardEntries,
  parameter int unsigned NR_COMMIT_PORTS = NrCommitPorts,
  parameter int unsigned NR_WB_PORTS     = NrWbPorts,
  parameter int unsigned DATA_W          = XLEN,
  localparam int unsigned ID_W           = id_w(NR_ENTRIES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic                                    issue_valid_i,
  output logic                                    issue_ready_o,
  output logic [ID_W-1:0]                         issue_id_o,
  input  logic [NR_WB_PORTS-1:0]                  wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][ID_W-1:0]        wb_id_i,
  input  logic [NR_WB_PORTS-1:0][DATA_W-1:0]      wb_data_i,
  output logic [NR_COMMIT_PORTS-1:0]              commit_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][ID_W-1:0]    commit_id_o,
  output logic [NR_COMMIT_PORTS-1:0][DATA_W-1:0]  commit_data_o,
  input  logic [NR_COMMIT_PORTS-1:0]              commit_ack_i,
  output logic [ID_W:0]                           count_o
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(NR_ENTRIES);

  sb_entry_t                                ent_q [NR_ENTRIES];
  logic [ID_W-1:0]                          head_q;
  logic [ID_W-1:0]                          tail_q;
  logic [ID_W:0]                            count_q;

  logic                                     issue_fire;
  logic [NR_COMMIT_PORTS-1:0]               win_ok;
  logic [NR_COMMIT_PORTS-1:0][ID_W-1:0]     win_idx;
  logic [NR_COMMIT_PORTS-1:0]               ack_fire;
  logic [ID_W:0]                            n_ack;

  assign issue_ready_o = (count_q < FULL_CNT);
  assign issue_id_o    = tail_q;
  assign count_o       = count_q;
  assign issue_fire    = issue_valid_i & issue_ready_o;

  // Retire window: port k is valid only if every entry from head up to head+k is done.
  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_win
    assign win_idx[k]        = head_q + ID_W'(k);
    assign win_ok[k]         = ent_q[win_idx[k]].valid & ent_q[win_idx[k]].done;
    assign commit_valid_o[k] = &win_ok[k:0];
    assign commit_id_o[k]    = win_idx[k];
    assign commit_data_o[k]  = ent_q[win_idx[k]].data[DATA_W-1:0];
  end

  assign ack_fire = commit_ack_i & commit_valid_o;

  always_comb begin
    n_ack = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      n_ack = n_ack + (ID_W+1)'(ack_fire[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].done  <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Qualification uses pre-edge state, so a later port overrides an earlier one
      // and a slot allocated this cycle is still invalid and ignores writebacks.
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && ent_q[wb_id_i[p]].valid && !ent_q[wb_id_i[p]].done) begin
          ent_q[wb_id_i[p]].done               <= 1'b1;
          ent_q[wb_id_i[p]].data[DATA_W-1:0]   <= wb_data_i[p];
        end
      end
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (ack_fire[k]) begin
          ent_q[win_idx[k]].valid <= 1'b0;
          ent_q[win_idx[k]].done  <= 1'b0;
        end
      end
      if (issue_fire) begin
        ent_q[tail_q].valid <= 1'b1;
        ent_q[tail_q].done  <= 1'b0;
      end
      head_q  <= head_q + n_ack[ID_W-1:0];
      tail_q  <= tail_q + ID_W'(issue_fire);
      count_q <= count_q + (ID_W+1)'(issue_fire) - n_ack;
    end
  end

`ifndef SYNTHESIS
  // Acks must form a contiguous prefix of valid retire ports.
  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_ack_chk
    if (k == 0) begin : g_first
      a_ack_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_ack_i[0] |-> commit_valid_o[0]);
    end else begin : g_rest
      a_ack_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_ack_i[k] |-> (commit_valid_o[k] && commit_ack_i[k-1]));
    end
  end
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue with an in-order queue reference model and per-cycle compare.
module tb_commit_queue;

  localparam int NE = 8;
  localparam int NC = 2;
  localparam int NW = 2;
  localparam int IW = 3;
  localparam int DW = 32;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [IW-1:0]            issue_id_o;
  logic [NW-1:0]            wb_valid_i;
  logic [NW-1:0][IW-1:0]    wb_id_i;
  logic [NW-1:0][DW-1:0]    wb_data_i;
  logic [NC-1:0]            commit_valid_o;
  logic [NC-1:0][IW-1:0]    commit_id_o;
  logic [NC-1:0][DW-1:0]    commit_data_o;
  logic [NC-1:0]            commit_ack_i;
  logic [IW:0]              count_o;

  commit_queue #(
    .NR_ENTRIES(NE), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW), .DATA_W(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_o(issue_id_o),
    .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_data_i(wb_data_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_data_o(commit_data_o),
    .commit_ack_i(commit_ack_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model: program-order list of live IDs plus per-ID done flag and result.
  int            q[$];
  bit            mdone [NE];
  logic [DW-1:0] mdata [NE];
  int            mhead;
  int            mtail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic bit live(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_cv(input int k);
    if (k >= q.size()) return 1'b0;
    for (int j = 0; j <= k; j++) if (!mdone[q[j]]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    mhead = 0;
    mtail = 0;
    for (int i = 0; i < NE; i++) mdone[i] = 1'b0;
  endtask

  task automatic model_update();
    bit            nd  [NE];
    logic [DW-1:0] nda [NE];
    int            nack;
    bit            iss;
    if (flush_i) begin
      model_reset();
      return;
    end
    nd   = mdone;
    nda  = mdata;
    nack = 0;
    iss  = issue_valid_i && (q.size() < NE);
    for (int p = 0; p < NW; p++) begin
      int id;
      id = int'(wb_id_i[p]);
      if (wb_valid_i[p] && live(id) && !mdone[id]) begin
        nd[id]  = 1'b1;
        nda[id] = wb_data_i[p];
      end
    end
    for (int k = 0; k < NC; k++) if (commit_ack_i[k]) nack++;
    for (int k = 0; k < nack; k++) void'(q.pop_front());
    if (iss) begin
      q.push_back(mtail);
      nd[mtail] = 1'b0;
      mtail     = (mtail + 1) % NE;
    end
    mhead = (mhead + nack) % NE;
    mdone = nd;
    mdata = nda;
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("ready", 64'(issue_ready_o), 64'(q.size() < NE));
      chk("issue_id", 64'(issue_id_o), 64'(mtail));
      chk("count", 64'(count_o), 64'(q.size()));
      for (int k = 0; k < NC; k++) begin
        bit ev;
        ev = exp_cv(k);
        chk($sformatf("commit_valid[%0d]", k), 64'(commit_valid_o[k]), 64'(ev));
        chk($sformatf("commit_id[%0d]", k), 64'(commit_id_o[k]), 64'((mhead + k) % NE));
        if (ev) chk($sformatf("commit_data[%0d]", k), 64'(commit_data_o[k]), 64'(mdata[q[k]]));
      end
    end
  end

  task automatic idle();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    wb_valid_i    = '0;
    wb_id_i       = '0;
    wb_data_i     = '0;
    commit_ack_i  = '0;
  endtask

  task automatic wb(input int p, input int id, input logic [DW-1:0] d);
    wb_valid_i[p] = 1'b1;
    wb_id_i[p]    = IW'(id);
    wb_data_i[p]  = d;
  endtask

  // Apply the current inputs for one edge, then return at the following negedge with inputs cleared.
  task automatic tick();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    idle();
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid_i = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_issue_id", 64'(issue_id_o), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    // Eight back-to-back issues receive IDs 0..7 and fill the queue.
    for (int i = 0; i < NE; i++) begin
      issue_valid_i = 1'b1;
      chk("fill_issue_id", 64'(issue_id_o), 64'(i));
      tick();
    end
    chk("full_count", 64'(count_o), 64'd8);
    chk("full_ready", 64'(issue_ready_o), 64'd0);

    // Out-of-order writeback: ID1 then ID0.
    wb(0, 1, 32'h1111_0001); tick();
    chk("wb1_cv", 64'(commit_valid_o), 64'b00);
    wb(0, 0, 32'h1111_0000); tick();
    chk("wb0_cv", 64'(commit_valid_o), 64'b11);
    chk("wb0_cid0", 64'(commit_id_o[0]), 64'd0);
    chk("wb0_cid1", 64'(commit_id_o[1]), 64'd1);
    chk("wb0_cdata1", 64'(commit_data_o[1]), 64'h1111_0001);
    commit_ack_i = 2'b11; tick();
    chk("ack2_head", 64'(commit_id_o[0]), 64'd2);
    chk("ack2_count", 64'(count_o), 64'd6);

    // Both ports write ID3 in one cycle: port 1 wins.
    wb(0, 3, 32'hAAAA_0003); wb(1, 3, 32'hBBBB_0003); tick();
    chk("dup_cv", 64'(commit_valid_o), 64'b00);
    wb(0, 2, 32'hCCCC_0002); tick();
    chk("dup_cv2", 64'(commit_valid_o), 64'b11);
    chk("dup_data0", 64'(commit_data_o[0]), 64'hCCCC_0002);
    chk("dup_data1", 64'(commit_data_o[1]), 64'hBBBB_0003);
    commit_ack_i = 2'b11; tick();
    chk("dup_count", 64'(count_o), 64'd4);

    // Refill, then issue and a single ack in the same cycle while full.
    issue_n(4);
    chk("refill_count", 64'(count_o), 64'd8);
    wb(1, 4, 32'h0000_0004); tick();
    chk("fullack_cv", 64'(commit_valid_o), 64'b01);
    issue_valid_i = 1'b1; commit_ack_i = 2'b01; tick();
    chk("fullack_count", 64'(count_o), 64'd7);
    chk("fullack_ready", 64'(issue_ready_o), 64'd1);
    chk("fullack_issue_id", 64'(issue_id_o), 64'd4);

    // Drain to five entries, then flush with concurrent issue, writeback and ack.
    wb(0, 5, 32'h0000_0005); wb(1, 6, 32'h0000_0006); tick();
    commit_ack_i = 2'b11; tick();
    chk("pre_flush_count", 64'(count_o), 64'd5);
    wb(0, 7, 32'h0000_0007); tick();
    flush_i = 1'b1; issue_valid_i = 1'b1; wb(1, 0, 32'hDEAD_0000); commit_ack_i = 2'b01; tick();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_issue_id", 64'(issue_id_o), 64'd0);
    chk("flush_cv", 64'(commit_valid_o), 64'b00);
    wb(0, 0, 32'hDEAD_0001); tick();
    chk("stale_wb_cv", 64'(commit_valid_o), 64'b00);

    // Advance head to 6, then wrap: entries 6,7,0,1 with tail=2.
    issue_n(6);
    wb(0, 0, 32'h0); wb(1, 1, 32'h1); tick();
    wb(0, 2, 32'h2); wb(1, 3, 32'h3); commit_ack_i = 2'b11; tick();
    wb(0, 4, 32'h4); wb(1, 5, 32'h5); commit_ack_i = 2'b11; tick();
    commit_ack_i = 2'b11; tick();
    chk("wrap_head6", 64'(commit_id_o[0]), 64'd6);
    issue_n(4);
    chk("wrap_tail2", 64'(issue_id_o), 64'd2);
    wb(0, 6, 32'h6666_0006); wb(1, 7, 32'h7777_0007); tick();
    chk("wrap_cv", 64'(commit_valid_o), 64'b11);
    chk("wrap_cid0", 64'(commit_id_o[0]), 64'd6);
    chk("wrap_cid1", 64'(commit_id_o[1]), 64'd7);
    chk("wrap_cdata1", 64'(commit_data_o[1]), 64'h7777_0007);
    commit_ack_i = 2'b11; tick();
    chk("wrap_head0", 64'(commit_id_o[0]), 64'd0);
    chk("wrap_count", 64'(count_o), 64'd2);

    // Writeback racing the issue of the same ID is dropped.
    wb(0, 0, 32'h10); wb(1, 1, 32'h11); tick();
    commit_ack_i = 2'b11; tick();
    issue_valid_i = 1'b1; wb(0, 2, 32'hBAD0_0002); tick();
    chk("race_cv", 64'(commit_valid_o), 64'b00);
    chk("race_count", 64'(count_o), 64'd1);
    wb(0, 2, 32'h2222_0002); tick();
    chk("race_cv2", 64'(commit_valid_o), 64'b01);
    chk("race_data", 64'(commit_data_o[0]), 64'h2222_0002);

    // Reset mid-operation discards live entries.
    issue_valid_i = 1'b1; tick();
    wb(0, 3, 32'h3333_0003); tick();
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_cv", 64'(commit_valid_o), 64'b00);
    chk("mid_rst_count", 64'(count_o), 64'd0);
    chk("mid_rst_ready", 64'(issue_ready_o), 64'd1);
    chk("mid_rst_issue_id", 64'(issue_id_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wb(0, 2, 32'hDEAD_0002); tick();
    chk("post_rst_cv", 64'(commit_valid_o), 64'b00);
    chk("post_rst_count", 64'(count_o), 64'd0);
    tick();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_queue.md
COMMIT_QUEUE -- requirements
Module: commit_queue

Interface
REQ-001 Parameter NR_ENTRIES, default 8, SHALL set queue depth; legal values are powers of two from 4 to 32.
REQ-002 Parameter NR_COMMIT_PORTS, default 2, SHALL set in-order retire ports per cycle; legal range is 1..4 and must not exceed NR_ENTRIES.
REQ-003 Parameter NR_WB_PORTS, default 2, SHALL set parallel writeback ports; legal range is 1..4.
REQ-004 Parameter DATA_W, default 32, SHALL set result width (XLEN).
REQ-005 Derived constant ID_W = $clog2(NR_ENTRIES) SHALL be the transaction-ID width.
REQ-006 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-007 Port list (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- flush_i  in  1  discard all entries.
- issue_valid_i  in  1  allocation request.
- issue_ready_o  out  1  slot free.
- issue_id_o  out  ID_W  ID granted to the current request.
- wb_valid_i  in  NR_WB_PORTS  writeback strobe per port.
- wb_id_i  in  NR_WB_PORTS x ID_W  writeback target ID.
- wb_data_i  in  NR_WB_PORTS x DATA_W  result.
- commit_valid_o  out  NR_COMMIT_PORTS  retire-ready per port.
- commit_id_o  out  NR_COMMIT_PORTS x ID_W  ID of the retiring entry.
- commit_data_o  out  NR_COMMIT_PORTS x DATA_W  result of the retiring entry.
- commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledge.
- count_o  out  ID_W+1  occupied entries.

Function
REQ-008 The queue SHALL be circular, with tail pointer (issue) and head pointer (commit), both ID_W bits wrapping modulo NR_ENTRIES, plus an occupancy counter of ID_W+1 bits.
REQ-009 issue_ready_o SHALL equal (count < NR_ENTRIES), computed from registered count only; a same-cycle commit SHALL NOT bypass into ready.
REQ-010 issue_id_o SHALL equal the tail pointer.
REQ-011 On issue_valid_i && issue_ready_o, the entry SHALL become valid with done=0 on the next edge, and the tail SHALL advance by 1.
REQ-012 A writeback on port p SHALL set done and store wb_data_i[p] only if its target entry is currently valid and not done; otherwise it SHALL be ignored.
REQ-013 If multiple writeback ports target the same ID in one cycle, the highest-index port SHALL win.
REQ-014 commit_valid_o[k] SHALL be 1 iff entries head+0 through head+k are all valid and done; commit_id_o[k] SHALL equal head+k (mod NR_ENTRIES).
REQ-015 Commit outputs SHALL be combinational from state: a writeback at edge t makes commit_valid_o visible in cycle t+1.
REQ-016 commit_ack_i[k] is legal only when commit_valid_o[k] and commit_ack_i[k-1] are both set.
REQ-017 An acked entry SHALL be invalidated, and head SHALL advance by the number of acks.
REQ-018 Each cycle, count SHALL update by +issue −acks.
REQ-019 Simultaneous issue and commit while full: the issue SHALL be rejected, and the commit SHALL proceed.
REQ-020 flush_i SHALL clear every valid and done bit, zero head, tail and count on the next edge, and override issue, writeback and ack in the same cycle.
REQ-021 A writeback in the same cycle as the issue that allocates that ID SHALL be ignored.
REQ-022 Illegal acks (violating REQ-016) SHALL trigger a simulation-only assertion.

Reset
REQ-023 While rst_ni=0, all state SHALL clear asynchronously: every valid and done bit 0, head, tail and count 0.
REQ-024 Output values during reset SHALL be: issue_ready_o=1, issue_id_o=0, commit_valid_o=0, count_o=0.
REQ-025 Result storage need not be reset.
REQ-026 Reset asserted mid-operation SHALL discard all entries, and no commit SHALL be produced afterwards for pre-reset IDs.

Structure
REQ-027 The entry typedef {valid, done, data} and the ID_W function SHALL live in the shared core package, alongside the NrCommitPorts and NrScoreboardEntries config constants that supply parameter defaults.
REQ-028 The block SHALL be single-module, with no sub-module; the head+k window logic SHALL be a generate loop.

Verification
REQ-029 Bench SHALL cover: 8 issues back-to-back -> IDs 0..7, ready=0 after the 8th, count_o=8.
REQ-030 Bench SHALL cover: writebacks to IDs 1 then 0, both acked -> commit_valid_o=00 after wb(1) and 11 after wb(0); head advances by 2.
REQ-031 Bench SHALL cover: full queue with issue and a 1-ack in the same cycle -> issue rejected, count 8→7, ready=1 the next cycle.
REQ-032 Bench SHALL cover: ports 0 and 1 both writing ID 3 (data A, B) -> commit_data_o carries B.
REQ-033 Bench SHALL cover: wrap-around with head=6, tail=2, entries 6,7 done -> commit_id_o = {7,6}; after acks, head=0.
REQ-034 Bench SHALL cover: flush with 5 entries and concurrent issue/wb/ack -> next cycle count_o=0, issue_id_o=0, commit_valid_o=0.
